shift_ring_counter: RTL and testbench

SHIFT_RING_COUNTER -- requirements
Module: shift_ring_counter

---
 rtl/shift_ring_counter_if.sv | 15 +
 rtl/shift_ring_counter.sv | 66 ++++++
 tb/tb_shift_ring_counter.sv | 109 ++++++++++
 3 files changed

// File: rtl/shift_ring_counter_if.sv
// shift_ring_counter_if: control inputs and counter outputs of shift_ring_counter, with master/slave views.
interface shift_ring_counter_if #(parameter int WIDTH_REG = 4);
  localparam int PW = $clog2(2 * WIDTH_REG);
  logic                 en;
  logic                 mode;
  logic                 dir;
  logic                 load;
  logic [WIDTH_REG-1:0] load_val;
  logic [WIDTH_REG-1:0] out;
  logic [PW-1:0]        phase;
  logic                 wrap;
  logic                 err;
  modport master (output en, mode, dir, load, load_val, input out, phase, wrap, err);
  modport slave  (input en, mode, dir, load, load_val, output out, phase, wrap, err);
endinterface

// File: rtl/shift_ring_counter.sv
// shift_ring_counter: Johnson/ring shift counter with phase decode, wrap pulse and illegal-state flag.
// Define SHIFT_RING_COUNTER_SELF_CORRECT_EN to reseed illegal states on the next edge.
module shift_ring_counter #(
  parameter int WIDTH_REG = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  shift_ring_counter_if.slave bus
);
  localparam int W  = WIDTH_REG;
  localparam int PW = $clog2(2 * W);
  logic [W-1:0] r_out;
  logic         r_mode;
  logic         r_wrap;
  logic [W-1:0] w_step;
  logic         w_err;
  function automatic logic [W-1:0] seed(input logic m);
    return {{(W-1){1'b0}}, m};
  endfunction
  // Johnson states have at most one boundary between adjacent differing bits
  function automatic logic is_legal(input logic [W-1:0] v, input logic m);
    logic [W-2:0] t;
    t = v[W-1:1] ^ v[W-2:0];
    return m ? (v != '0 && (v & (v - W'(1))) == '0) : ((t & (t - (W-1)'(1))) == '0);
  endfunction
  function automatic logic [PW-1:0] phase_of(input logic [W-1:0] v, input logic m);
    int pc;
    int idx;
    pc  = 0;
    idx = 0;
    for (int k = 0; k < W; k++) begin
      pc += int'(v[k]);
      if (v[k]) idx = k;
    end
    if (!is_legal(v, m)) return '0;
    if (m) return PW'((W - idx) % W);
    if (v[W-1]) return PW'(pc);
    return (v == '0) ? '0 : PW'(2 * W - pc);
  endfunction
  assign w_step    = bus.dir ? {r_out[W-2:0], r_out[W-1] ^ ~r_mode} : {r_out[0] ^ ~r_mode, r_out[W-1:1]};
  assign w_err     = !is_legal(r_out, r_mode);
  assign bus.out   = r_out;
  assign bus.wrap  = r_wrap;
  assign bus.err   = w_err;
  assign bus.phase = phase_of(r_out, r_mode);
  always_ff @(posedge clk) begin
    if (!n_rst || bus.mode != r_mode) begin
      r_out  <= seed(bus.mode);
      r_mode <= bus.mode;
      r_wrap <= 1'b0;
    end else if (bus.load) begin
      r_out  <= bus.load_val;
      r_wrap <= 1'b0;
`ifdef SHIFT_RING_COUNTER_SELF_CORRECT_EN
    end else if (w_err) begin
      r_out  <= seed(r_mode);
      r_wrap <= 1'b0;
`endif
    end else if (bus.en) begin
      r_out  <= w_step;
      r_wrap <= is_legal(w_step, r_mode) && phase_of(w_step, r_mode) == '0;
    end else begin
      r_wrap <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_ring_counter.sv
// tb_shift_ring_counter: directed vectors feed an expectation queue that a monitor checks each cycle.
module tb_shift_ring_counter;
  typedef struct {
    logic [3:0] o;
    logic [2:0] p;
    logic       w;
    logic       e;
    string      nm;
  } exp_t;
  logic clk;
  logic n_rst;
  int   checks;
  int   errors;
  exp_t q[$];
  shift_ring_counter_if #(.WIDTH_REG(4)) bus ();
  shift_ring_counter #(.WIDTH_REG(4)) dut (.clk(clk), .n_rst(n_rst), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %0h want %0h", nm, fld, act, exp);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.nm, "out", {4'b0, bus.out}, {4'b0, e.o});
        cmp(e.nm, "phase", {5'b0, bus.phase}, {5'b0, e.p});
        cmp(e.nm, "wrap", {7'b0, bus.wrap}, {7'b0, e.w});
        cmp(e.nm, "err", {7'b0, bus.err}, {7'b0, e.e});
      end
    end
  end
  task automatic cyc(input logic rn, input logic m, input logic d, input logic en, input logic ld,
                     input logic [3:0] lv, input logic [3:0] xo, input logic [2:0] xp,
                     input logic xw, input logic xe, input string nm);
    @(negedge clk);
    n_rst        = rn;
    bus.mode     = m;
    bus.dir      = d;
    bus.en       = en;
    bus.load     = ld;
    bus.load_val = lv;
    q.push_back('{xo, xp, xw, xe, nm});
  endtask
  initial begin
    n_rst = 1'b0; bus.mode = 1'b0; bus.dir = 1'b0; bus.en = 1'b0; bus.load = 1'b0; bus.load_val = 4'h0;
    cyc(0, 0, 0, 0, 0, 4'h0, 4'b0000, 0, 0, 0, "reset_j");
    cyc(1, 0, 0, 1, 0, 4'h0, 4'b1000, 1, 0, 0, "j_dn1");
    cyc(1, 0, 0, 1, 0, 4'h0, 4'b1100, 2, 0, 0, "j_dn2");
    cyc(1, 0, 0, 1, 0, 4'h0, 4'b1110, 3, 0, 0, "j_dn3");
    cyc(1, 0, 0, 1, 0, 4'h0, 4'b1111, 4, 0, 0, "j_dn4");
    cyc(1, 0, 0, 1, 0, 4'h0, 4'b0111, 5, 0, 0, "j_dn5");
    cyc(1, 0, 0, 1, 0, 4'h0, 4'b0011, 6, 0, 0, "j_dn6");
    cyc(1, 0, 0, 1, 0, 4'h0, 4'b0001, 7, 0, 0, "j_dn7");
    cyc(1, 0, 0, 1, 0, 4'h0, 4'b0000, 0, 1, 0, "j_dn_wrap");
    cyc(1, 0, 0, 0, 0, 4'h0, 4'b0000, 0, 0, 0, "j_hold");
    cyc(1, 0, 1, 1, 0, 4'h0, 4'b0001, 7, 0, 0, "j_up1");
    cyc(1, 0, 1, 1, 0, 4'h0, 4'b0011, 6, 0, 0, "j_up2");
    cyc(1, 0, 1, 1, 0, 4'h0, 4'b0111, 5, 0, 0, "j_up3");
    cyc(1, 0, 1, 1, 0, 4'h0, 4'b1111, 4, 0, 0, "j_up4");
    cyc(1, 0, 1, 1, 0, 4'h0, 4'b1110, 3, 0, 0, "j_up5");
    cyc(0, 0, 1, 1, 1, 4'hF, 4'b0000, 0, 0, 0, "rst_prio");
    cyc(0, 1, 0, 1, 0, 4'h0, 4'b0001, 0, 0, 0, "reset_r");
    cyc(1, 1, 0, 1, 0, 4'h0, 4'b1000, 1, 0, 0, "r_dn1");
    cyc(1, 1, 0, 1, 0, 4'h0, 4'b0100, 2, 0, 0, "r_dn2");
    cyc(1, 1, 0, 1, 0, 4'h0, 4'b0010, 3, 0, 0, "r_dn3");
    cyc(1, 1, 0, 1, 0, 4'h0, 4'b0001, 0, 1, 0, "r_dn_wrap");
    cyc(1, 1, 1, 1, 0, 4'h0, 4'b0010, 3, 0, 0, "r_up1");
    cyc(1, 1, 1, 0, 0, 4'h0, 4'b0010, 3, 0, 0, "r_hold");
    cyc(1, 0, 0, 1, 0, 4'h0, 4'b0000, 0, 0, 0, "reseed_j");
    cyc(1, 0, 0, 1, 0, 4'h0, 4'b1000, 1, 0, 0, "pre_1000");
    cyc(1, 0, 0, 1, 0, 4'h0, 4'b1100, 2, 0, 0, "pre_1100");
    cyc(1, 1, 0, 0, 1, 4'hF, 4'b0001, 0, 0, 0, "reseed_vs_load");
    cyc(1, 0, 0, 0, 0, 4'h0, 4'b0000, 0, 0, 0, "reseed_back");
    cyc(1, 0, 0, 1, 1, 4'h5, 4'b0101, 0, 0, 1, "load_illegal");
`ifdef SHIFT_RING_COUNTER_SELF_CORRECT_EN
    cyc(1, 0, 0, 1, 0, 4'h0, 4'b0000, 0, 0, 0, "correct");
    cyc(1, 0, 0, 1, 0, 4'h0, 4'b1000, 1, 0, 0, "after_correct");
`else
    cyc(1, 0, 0, 1, 0, 4'h0, 4'b0010, 0, 0, 1, "illegal_step1");
    cyc(1, 0, 0, 1, 0, 4'h0, 4'b1001, 0, 0, 1, "illegal_step2");
`endif
    cyc(1, 0, 0, 1, 1, 4'h0, 4'b0000, 0, 0, 0, "load_zero_nowrap");
    cyc(1, 0, 0, 0, 1, 4'h7, 4'b0111, 5, 0, 0, "load_legal");
    @(negedge clk);
    bus.en = 1'b0;
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
